instr_mem_ldr: RTL and testbench

Parametrised instruction memory with two ports: a streaming load port and a registered fetch port. The load port takes words over a valid/ready handshake and writes them to auto-incrementing addresses from a base address. The fetch port gives the CPU fetch stage a one-cycle-latency read and raises a stall while a load session owns the array. This block replaces the fixed 4K×16 single-port instruction memory, whose write-enable was shared with the read path.

---
 rtl/instr_mem_ldr.sv | 98 +++++++++
 tb/tb_instr_mem_ldr.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_ldr.sv
// instr_mem_ldr: instruction memory with a streaming load port and a registered fetch port.
module instr_mem_ldr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_abort,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [DATA_W-1:0] ld_csum,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_stall
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0] full_len = {1'b1, {ADDR_W{1'b0}}};
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] csum_q, csum_d, fdata_q, fdata_d;
  logic              err_q, err_d, fvalid_q, fvalid_d;
  logic              go, we;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign go = (state_q == IDLE) & ld_start & ~ld_abort;
  assign we = (state_q == LOAD) & ld_valid & ~ld_abort;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      csum_q   <= '0;
      err_q    <= 1'b0;
      fdata_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
      fdata_q  <= fdata_d;
      fvalid_q <= fvalid_d;
    end
  end
  // array contents deliberately survive reset
  always_ff @(posedge clk) if (we) mem[ptr_q] <= ld_data;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (go) begin
        if (ld_len > full_len) err_d = 1'b1;
        else begin
          ptr_d   = ld_base;
          rem_d   = ld_len;
          csum_d  = '0;
          state_d = (ld_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: if (ld_abort) state_d = IDLE;
      else if (ld_valid) begin
        ptr_d   = ptr_q + (ADDR_W)'(1);
        rem_d   = rem_q - (ADDR_W+1)'(1);
        csum_d  = csum_q ^ ld_data;
        state_d = (rem_q == (ADDR_W+1)'(1)) ? DONE : LOAD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    fvalid_d = fetch_req & (state_q != LOAD);
    fdata_d  = fvalid_d ? mem[fetch_addr] : fdata_q;
  end
  always_comb begin
    ld_ready    = state_q == LOAD;
    ld_busy     = state_q == LOAD;
    fetch_stall = state_q == LOAD;
    ld_done     = state_q == DONE;
    ld_err      = err_q;
    ld_csum     = csum_q;
    fetch_data  = fdata_q;
    fetch_valid = fvalid_q;
  end
endmodule

// File: tb/tb_instr_mem_ldr.sv
// tb_instr_mem_ldr: directed vectors and hand-written sequences for instr_mem_ldr.
module tb_instr_mem_ldr;
  logic        clk = 1'b0, rst_n;
  logic        ld_start, ld_abort, ld_valid, fetch_req;
  logic [11:0] ld_base, fetch_addr;
  logic [12:0] ld_len;
  logic [15:0] ld_data, ld_csum, fetch_data;
  logic        ld_ready, ld_busy, ld_done, ld_err, fetch_valid, fetch_stall;
  int total = 0, bad = 0;
  typedef struct {logic [11:0] addr; logic [15:0] exp;} vec_t;
  vec_t vecs [6];
  logic [15:0] acc;
  instr_mem_ldr #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_abort(ld_abort), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err), .ld_csum(ld_csum),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_stall(fetch_stall)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic start(input logic [11:0] base, input logic [12:0] len);
    ld_start = 1'b1;
    ld_base  = base;
    ld_len   = len;
    tick();
    ld_start = 1'b0;
  endtask
  task automatic fetch1(input string nm, input logic [11:0] a, input logic [15:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    chk({nm, "_valid"}, 32'(fetch_valid), 32'd1);
    chk({nm, "_data"}, 32'(fetch_data), 32'(exp));
  endtask
  initial begin
    vecs[0] = '{12'h000, 16'hD000};
    vecs[1] = '{12'h001, 16'hD001};
    vecs[2] = '{12'h7FF, 16'hD7FF};
    vecs[3] = '{12'h800, 16'hD800};
    vecs[4] = '{12'hABC, 16'hDABC};
    vecs[5] = '{12'hFFF, 16'hDFFF};
    rst_n = 1'b0; ld_start = 0; ld_abort = 0; ld_valid = 0; fetch_req = 0;
    ld_base = '0; ld_len = '0; ld_data = '0; fetch_addr = '0;
    #2;
    chk("rst_outs", {ld_ready, ld_busy, ld_done, ld_err, fetch_valid, fetch_stall}, 0);
    chk("rst_csum", 32'(ld_csum), 0);
    chk("rst_fdata", 32'(fetch_data), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // basic load and fetch
    start(12'h001, 13'd2);
    chk("basic_ready", 32'(ld_ready), 1);
    chk("basic_stall", 32'(fetch_stall), 1);
    ld_valid = 1; ld_data = 16'h02A3; tick();
    ld_data = 16'h00FF; tick();
    ld_valid = 0;
    chk("basic_done", {ld_done, ld_ready, fetch_stall}, 3'b100);
    chk("basic_csum", 32'(ld_csum), 32'h025C);
    tick();
    chk("basic_done_pulse", {ld_done, ld_busy}, 0);
    fetch1("basic_f1", 12'h001, 16'h02A3);
    fetch1("basic_f2", 12'h002, 16'h00FF);
    // wrap with bubbles
    start(12'hFFE, 13'd4);
    begin
      logic [5:0] pat = 6'b101101;
      int n = 0;
      for (int i = 0; i < 6; i++) begin
        chk("wrap_busy", 32'(ld_busy), 1);
        ld_valid = pat[5-i];
        ld_data  = 16'hA000 + 16'(n);
        if (pat[5-i]) n++;
        tick();
      end
    end
    ld_valid = 0;
    chk("wrap_done", 32'(ld_done), 1);
    tick();
    fetch1("wrap_ffe", 12'hFFE, 16'hA000);
    fetch1("wrap_fff", 12'hFFF, 16'hA001);
    fetch1("wrap_000", 12'h000, 16'hA002);
    fetch1("wrap_001", 12'h001, 16'hA003);
    // stall: fetch held across a 3-word load, then a fetch in DONE sees new data
    start(12'h100, 13'd3);
    fetch_req = 1; fetch_addr = 12'h101;
    for (int i = 0; i < 3; i++) begin
      chk("stall_stall", 32'(fetch_stall), 1);
      if (i > 0) chk("stall_valid", 32'(fetch_valid), 0);
      ld_valid = 1; ld_data = 16'hB000 + 16'(i);
      tick();
    end
    ld_valid = 0;
    chk("stall_done", {ld_done, fetch_stall, fetch_valid}, 3'b100);
    tick();
    fetch_req = 0;
    chk("stall_resume_valid", 32'(fetch_valid), 1);
    chk("stall_resume_data", 32'(fetch_data), 32'hB001);
    // abort: preload 0x202 then show the aborted beat never lands there
    start(12'h202, 13'd1);
    ld_valid = 1; ld_data = 16'h5555; tick();
    ld_valid = 0; tick();
    start(12'h200, 13'd5);
    ld_valid = 1; ld_data = 16'hC001; tick();
    ld_data = 16'hC002; tick();
    ld_data = 16'hC003; ld_abort = 1; tick();
    ld_valid = 0; ld_abort = 0;
    chk("abort_idle", {ld_busy, ld_done, ld_ready}, 0);
    chk("abort_csum", 32'(ld_csum), 32'h0003);
    tick();
    chk("abort_no_done", 32'(ld_done), 0);
    fetch1("abort_200", 12'h200, 16'hC001);
    fetch1("abort_201", 12'h201, 16'hC002);
    fetch1("abort_202", 12'h202, 16'h5555);
    // abort wins over start in IDLE
    ld_abort = 1; start(12'h000, 13'd1); ld_abort = 0;
    chk("abort_start", {ld_busy, ld_done}, 0);
    // zero length
    start(12'h202, 13'd0);
    chk("zero_done", {ld_done, ld_busy}, 2'b10);
    chk("zero_csum", 32'(ld_csum), 0);
    tick();
    chk("zero_pulse", 32'(ld_done), 0);
    fetch1("zero_nowrite", 12'h202, 16'h5555);
    // oversize length rejected
    start(12'h202, 13'h1001);
    chk("err_pulse", {ld_err, ld_busy, ld_done}, 3'b100);
    tick();
    chk("err_clear", 32'(ld_err), 0);
    fetch1("err_nowrite", 12'h202, 16'h5555);
    // full 4096-word load
    start(12'h000, 13'h1000);
    acc = '0;
    for (int i = 0; i < 4096; i++) begin
      if (i == 4095) chk("full_busy", 32'(ld_busy), 1);
      ld_valid = 1; ld_data = 16'hD000 | 16'(i);
      acc ^= ld_data;
      tick();
    end
    ld_valid = 0;
    chk("full_done", 32'(ld_done), 1);
    chk("full_csum", 32'(ld_csum), 32'(acc));
    tick();
    fetch_req = 1;
    for (int i = 0; i < 6; i++) begin
      fetch_addr = vecs[i].addr;
      tick();
      chk("full_vec_valid", 32'(fetch_valid), 1);
      chk($sformatf("full_vec_%h", vecs[i].addr), 32'(fetch_data), 32'(vecs[i].exp));
    end
    fetch_req = 0;
    tick();
    // asynchronous reset in mid-load
    start(12'h300, 13'd8);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = 16'hE000 + 16'(i); tick();
    end
    ld_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {ld_ready, ld_busy, ld_done, ld_err, fetch_valid, fetch_stall}, 0);
    chk("mid_rst_csum", 32'(ld_csum), 0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch1("rst_300", 12'h300, 16'hE000);
    fetch1("rst_301", 12'h301, 16'hE001);
    fetch1("rst_302", 12'h302, 16'hE002);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
